// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants and writeback request types.
package lc3_pkg;

  localparam int LC3_WIDTH = 16;
  localparam int LC3_NREG  = 8;
  localparam int LC3_RA_W  = 3;

  typedef logic [LC3_RA_W-1:0] lc3_reg_addr_t;

  typedef struct packed {
    logic                 valid;
    lc3_reg_addr_t        addr;
    logic [LC3_WIDTH-1:0] data;
  } lc3_wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a rotating priority pointer.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         hold,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // Scan from ptr upward (wrapping) for the first valid request.
  always_comb begin
    gnt     = '0;
    ptr_d   = ptr_q;
    idx_s   = '0;
    found_s = 1'b0;
    if (rst_n && !hold) begin
      for (int k = 0; k < N; k++) begin
        idx_s = PW'((int'(ptr_q) + k) % N);
        if (!found_s && req[idx_s]) begin
          found_s    = 1'b1;
          gnt[idx_s] = 1'b1;
          ptr_d      = (idx_s == PW'(N - 1)) ? '0 : idx_s + PW'(1);
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      gnt = '0;
    end
  end

  // Pointer register; advances only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant, registered write port,
// and per-register pending scoreboard for decode hazard detection.
module regfile_wb_arbiter
  import lc3_pkg::*;
#(
  parameter int WIDTH = LC3_WIDTH,
  parameter int NREQ  = 3,
  parameter int NREG  = LC3_NREG,
  parameter int AW    = LC3_RA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wb_hold,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic [NREG-1:0]       busy,
  output logic                  rf_wr_en,
  output logic [AW-1:0]         rf_wr_addr,
  output logic [WIDTH-1:0]      rf_wr_data
);

  logic [NREQ-1:0]  gnt_s;
  logic             wr_en_d,   wr_en_q;
  logic [AW-1:0]    wr_addr_d, wr_addr_q;
  logic [WIDTH-1:0] wr_data_d, wr_data_q;
  logic [NREG-1:0]  busy_d,    busy_q;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .hold  (wb_hold),
    .gnt   (gnt_s)
  );

  assign req_ready = gnt_s;

  // Select the granted request; address/data hold when nothing is granted.
  always_comb begin
    wr_en_d   = |gnt_s;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s[i]) begin
        wr_addr_d = req_addr[i*AW +: AW];
        wr_data_d = req_data[i*WIDTH +: WIDTH];
      end else begin
        wr_en_d = wr_en_d;
      end
    end
  end

  // Scoreboard: a reservation on the same edge as the completing write wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (rsv_en) begin
      busy_d[rsv_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Output and scoreboard registers; reset drops any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter; inputs change and outputs are
// sampled just after the falling edge, state advances on the rising edge.
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 3;
  localparam int NREG  = 8;
  localparam int AW    = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wb_hold;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic [NREG-1:0]       busy;
  logic                  rf_wr_en;
  logic [AW-1:0]         rf_wr_addr;
  logic [WIDTH-1:0]      rf_wr_data;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wb_hold    (wb_hold),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .busy       (busy),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_addr[i*AW +: AW]       = a;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  // Advance to the next falling edge; the caller then drives and checks.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    check({tag, "_en"}, 32'(rf_wr_en), 32'(en));
    check({tag, "_addr"}, 32'(rf_wr_addr), 32'(a));
    check({tag, "_data"}, 32'(rf_wr_data), 32'(d));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    wb_hold   = 1'b0;
    rsv_en    = 1'b0;
    rsv_addr  = 3'd0;

    // Reset with all requesters valid
    nxt(); nxt(); settle();
    check("rst_ready", 32'(req_ready), 32'(3'b000));
    chk_wr("rst_wr", 1'b0, 3'd0, 16'h0000);
    check("rst_busy", 32'(busy), 32'(8'h00));

    // Release: requester 0 first
    nxt(); rst_n = 1'b1; settle();
    check("rel_ready", 32'(req_ready), 32'(3'b001));

    // Single write from requester 0 (ptr -> 1)
    req_valid = 3'b001; set_req(0, 3'd3, 16'hBEEF); settle();
    check("single_ready", 32'(req_ready), 32'(3'b001));
    nxt(); req_valid = 3'b000; settle();
    chk_wr("single_wr", 1'b1, 3'd3, 16'hBEEF);
    check("single_ready_off", 32'(req_ready), 32'(3'b000));
    nxt(); settle();
    chk_wr("single_idle", 1'b0, 3'd3, 16'hBEEF);

    // Requester 2 write brings ptr back to 0
    req_valid = 3'b100; set_req(2, 3'd6, 16'h6666); settle();
    check("r2_ready", 32'(req_ready), 32'(3'b100));
    nxt(); req_valid = 3'b000; settle();
    chk_wr("r2_wr", 1'b1, 3'd6, 16'h6666);

    // Round-robin with all valid for 6 cycles
    set_req(0, 3'd1, 16'h1111); set_req(1, 3'd2, 16'h2222); set_req(2, 3'd4, 16'h4444);
    nxt(); req_valid = 3'b111; settle();
    check("rr_g0", 32'(req_ready), 32'(3'b001));
    nxt(); settle();
    check("rr_g1", 32'(req_ready), 32'(3'b010));
    chk_wr("rr_w0", 1'b1, 3'd1, 16'h1111);
    nxt(); settle();
    check("rr_g2", 32'(req_ready), 32'(3'b100));
    chk_wr("rr_w1", 1'b1, 3'd2, 16'h2222);
    nxt(); settle();
    check("rr_g3", 32'(req_ready), 32'(3'b001));
    chk_wr("rr_w2", 1'b1, 3'd4, 16'h4444);
    nxt(); settle();
    check("rr_g4", 32'(req_ready), 32'(3'b010));
    chk_wr("rr_w3", 1'b1, 3'd1, 16'h1111);
    nxt(); settle();
    check("rr_g5", 32'(req_ready), 32'(3'b100));
    chk_wr("rr_w4", 1'b1, 3'd2, 16'h2222);
    nxt(); req_valid = 3'b000; settle();
    chk_wr("rr_w5", 1'b1, 3'd4, 16'h4444);

    // Move ptr to 1, then 101 grants 100 then 001
    req_valid = 3'b001; settle();
    nxt(); req_valid = 3'b101; settle();
    check("rr101_a", 32'(req_ready), 32'(3'b100));
    nxt(); settle();
    check("rr101_b", 32'(req_ready), 32'(3'b001));
    chk_wr("rr101_wa", 1'b1, 3'd4, 16'h4444);
    nxt(); req_valid = 3'b000; settle();
    chk_wr("rr101_wb", 1'b1, 3'd1, 16'h1111);

    // Scoreboard: reserve R5 (ptr is 1 here)
    rsv_en = 1'b1; rsv_addr = 3'd5;
    nxt(); rsv_en = 1'b0; settle();
    check("sb_set", 32'(busy), 32'(8'h20));
    req_valid = 3'b100; set_req(2, 3'd5, 16'h5555); settle();
    check("sb_wr_ready", 32'(req_ready), 32'(3'b100));
    nxt(); req_valid = 3'b000; settle();
    chk_wr("sb_wr", 1'b1, 3'd5, 16'h5555);
    check("sb_busy_inflight", 32'(busy), 32'(8'h20));
    nxt(); settle();
    check("sb_clear", 32'(busy), 32'(8'h00));

    // Reservation on the same edge as the clear keeps the bit set
    rsv_en = 1'b1; rsv_addr = 3'd5; req_valid = 3'b100;
    nxt(); rsv_en = 1'b0; req_valid = 3'b000; settle();
    check("sb_set2", 32'(busy), 32'(8'h20));
    chk_wr("sb_wr2", 1'b1, 3'd5, 16'h5555);
    rsv_en = 1'b1; rsv_addr = 3'd5;
    nxt(); rsv_en = 1'b0; settle();
    check("sb_set_wins", 32'(busy), 32'(8'h20));
    nxt(); settle();
    check("sb_still_set", 32'(busy), 32'(8'h20));

    // Hold for 2 cycles with 011 pending (ptr is 0 here)
    set_req(0, 3'd6, 16'hAAAA); set_req(1, 3'd7, 16'hBBBB);
    req_valid = 3'b011; wb_hold = 1'b1; settle();
    check("hold_ready0", 32'(req_ready), 32'(3'b000));
    nxt(); settle();
    check("hold_ready1", 32'(req_ready), 32'(3'b000));
    check("hold_nowr", 32'(rf_wr_en), 32'(1'b0));
    nxt(); wb_hold = 1'b0; settle();
    check("hold_nowr2", 32'(rf_wr_en), 32'(1'b0));
    check("hold_rel_g0", 32'(req_ready), 32'(3'b001));
    nxt(); req_valid = 3'b010; settle();
    check("hold_rel_g1", 32'(req_ready), 32'(3'b010));
    chk_wr("hold_w0", 1'b1, 3'd6, 16'hAAAA);
    nxt(); req_valid = 3'b000; settle();
    chk_wr("hold_w1", 1'b1, 3'd7, 16'hBBBB);
    nxt(); settle();
    check("hold_idle", 32'(rf_wr_en), 32'(1'b0));

    // Mid-flight reset drops the write and clears busy
    rsv_en = 1'b1; rsv_addr = 3'd3; req_valid = 3'b001; set_req(0, 3'd3, 16'hCCCC);
    nxt(); rsv_en = 1'b0; req_valid = 3'b000; settle();
    chk_wr("mid_inflight", 1'b1, 3'd3, 16'hCCCC);
    check("mid_busy_pre", 32'(busy), 32'(8'h28));
    rst_n = 1'b0; settle();
    chk_wr("mid_rst", 1'b0, 3'd0, 16'h0000);
    check("mid_rst_busy", 32'(busy), 32'(8'h00));
    nxt(); rst_n = 1'b1; settle();
    nxt(); settle();
    check("mid_post_en", 32'(rf_wr_en), 32'(1'b0));
    check("mid_post_busy", 32'(busy), 32'(8'h00));
    req_valid = 3'b111; settle();
    check("mid_post_ptr", 32'(req_ready), 32'(3'b001));
    req_valid = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
